mem_req_buffer: RTL and testbench
=================================

MEM_REQ_BUFFER -- requirements
Module: mem_req_buffer

Interface
REQ-001 Parameter ADDR_W, default 32: address width in bits.
REQ-002 Parameter DATA_W, default 32: data width in bits; SHALL be a multiple of 8, and BE_W = DATA_W/8.
REQ-003 Parameter DEPTH, default 4: request-queue entries; SHALL be a power of 2 and >= 2.
REQ-004 Parameter MAX_OUT, default 4: maximum reads issued to memory without a returned response; SHALL be >= 1.
REQ-005 clk  in  1  the single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 req_valid_i  in  1  core request valid.
REQ-008 req_ready_o  out  1  buffer can accept a request.
REQ-009 req_addr_i / req_we_i / req_be_i / req_wdata_i  in  ADDR_W / 1 / BE_W / DATA_W  address, 0=read 1=write, byte enables, write data.
REQ-010 mem_valid_o  out  1  request presented to memory.
REQ-011 mem_ready_i  in  1  memory accepts the presented request.
REQ-012 mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  out  ADDR_W / 1 / BE_W / DATA_W  head-entry fields.
REQ-013 mem_rvalid_i / mem_rdata_i  in  1 / DATA_W  memory read response, in issue order.
REQ-014 resp_rvalid_o / resp_rdata_o  out  1 / DATA_W  registered read response to core.
REQ-015 count_o  out  $clog2(DEPTH+1)  queued entries; outstanding_o  out  $clog2(MAX_OUT+1)  issued-unanswered reads.
REQ-016 idle_o  out  1  queue empty and outstanding_o == 0; err_o  out  1  sticky protocol error.

Function
REQ-017 Accept: on a rising edge with req_valid_i && req_ready_o, the request SHALL be written at the tail and count incremented.
REQ-018 req_ready_o SHALL equal (count_o != DEPTH) and SHALL be 0 while rst_n is low; no request is accepted when full.
REQ-019 No bypass: an accepted request SHALL NOT appear on mem_* earlier than the cycle after acceptance (minimum latency 1 cycle).
REQ-020 mem_valid_o SHALL be 1 iff the queue is non-empty and NOT (head is a read AND outstanding_o == MAX_OUT).
REQ-021 mem_* fields SHALL reflect the head entry and remain stable while mem_valid_o && !mem_ready_i.
REQ-022 Issue: mem_valid_o && mem_ready_i SHALL pop the head; if the head is a read, outstanding SHALL increment.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-024 mem_rvalid_i with outstanding_o > 0 SHALL decrement outstanding; a simultaneous read issue and response SHALL leave it unchanged.
REQ-025 mem_rvalid_i with outstanding_o == 0 SHALL set err_o, leave outstanding at 0 and produce no resp_rvalid_o.
REQ-026 resp_rvalid_o/resp_rdata_o SHALL be the registered copy of a valid mem_rvalid_i/mem_rdata_i, 1 cycle later; rdata holds its last value when rvalid is 0.
REQ-027 Writes SHALL never be blocked by the outstanding limit and SHALL produce no response.
REQ-028 Requests SHALL be issued strictly in acceptance order; a blocked read head SHALL block all younger entries.
REQ-029 err_o SHALL clear only on reset.

Reset
REQ-030 While rst_n is sampled low: count, pointers, outstanding, resp_rvalid_o and err_o SHALL be 0, resp_rdata_o SHALL be 0 and mem_valid_o SHALL be 0; idle_o SHALL be 1.
REQ-031 Reset mid-operation SHALL discard queued entries and outstanding reads; responses arriving after reset SHALL set err_o per REQ-025.

Verification
REQ-032 Fill: 4 writes with mem_ready_i=0 -> count_o=4, req_ready_o=0, 5th request not accepted; mem_addr_o stays at the first address.
REQ-033 Read limit: MAX_OUT=2, 3 reads with mem_ready_i=1 and no responses -> 2 issued, outstanding_o=2, mem_valid_o=0 until mem_rvalid_i arrives, then the 3rd read issues.
REQ-034 Response: read issued, mem_rvalid_i=1 with rdata=32'hDEADBEEF at cycle N -> resp_rvalid_o=1 and resp_rdata_o=32'hDEADBEEF at N+1, and outstanding_o decrements.
REQ-035 Simultaneous events: push+pop at count=2 -> count stays 2; read issue plus response at outstanding=1 -> stays 1.
REQ-036 Spurious response: mem_rvalid_i at outstanding_o=0 -> err_o=1 persists, no resp_rvalid_o.
REQ-037 Reset with 3 entries and outstanding=2 -> next cycle count_o=0, outstanding_o=0, idle_o=1, mem_valid_o=0.

Source files
------------

// File: rtl/mem_req_buffer.sv
// In-order memory request queue between a core and memory. Caps the number of
// reads in flight and registers read responses back to the core.
module mem_req_buffer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [ADDR_W-1:0]                req_addr_i,
  input  logic                             req_we_i,
  input  logic [DATA_W/8-1:0]              req_be_i,
  input  logic [DATA_W-1:0]                req_wdata_i,
  output logic                             mem_valid_o,
  input  logic                             mem_ready_i,
  output logic [ADDR_W-1:0]                mem_addr_o,
  output logic                             mem_we_o,
  output logic [DATA_W/8-1:0]              mem_be_o,
  output logic [DATA_W-1:0]                mem_wdata_o,
  input  logic                             mem_rvalid_i,
  input  logic [DATA_W-1:0]                mem_rdata_i,
  output logic                             resp_rvalid_o,
  output logic [DATA_W-1:0]                resp_rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o,
  output logic [$clog2(MAX_OUT+1)-1:0]     outstanding_o,
  output logic                             idle_o,
  output logic                             err_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OUT_W = $clog2(MAX_OUT+1);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                we;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic [OUT_W-1:0]   r_out;
  logic               r_err, r_rvalid;
  logic [DATA_W-1:0]  r_rdata;

  entry_t w_head;
  logic   w_push, w_pop, w_issue_rd, w_resp, w_blocked;

  assign w_head      = r_mem[r_rptr];
  // A read head at the in-flight cap stalls the whole queue to keep issue order.
  assign w_blocked   = !w_head.we && (r_out == OUT_W'(MAX_OUT));
  assign req_ready_o = rst_n && (r_count != CNT_W'(DEPTH));
  assign mem_valid_o = rst_n && (r_count != '0) && !w_blocked;
  assign w_push      = req_valid_i && req_ready_o;
  assign w_pop       = mem_valid_o && mem_ready_i;
  assign w_issue_rd  = w_pop && !w_head.we;
  assign w_resp      = mem_rvalid_i && (r_out != '0);

  assign mem_addr_o    = w_head.addr;
  assign mem_we_o      = w_head.we;
  assign mem_be_o      = w_head.be;
  assign mem_wdata_o   = w_head.wdata;
  assign count_o       = r_count;
  assign outstanding_o = r_out;
  assign idle_o        = !rst_n || ((r_count == '0) && (r_out == '0));
  assign err_o         = r_err;
  assign resp_rvalid_o = r_rvalid;
  assign resp_rdata_o  = r_rdata;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{req_addr_i, req_we_i, req_be_i, req_wdata_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_out    <= '0;
      r_err    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      case ({w_issue_rd, w_resp})
        2'b10:   r_out <= r_out + OUT_W'(1);
        2'b01:   r_out <= r_out - OUT_W'(1);
        default: r_out <= r_out;
      endcase
      if (mem_rvalid_i && (r_out == '0)) r_err <= 1'b1;
      r_rvalid <= w_resp;
      if (w_resp) r_rdata <= mem_rdata_i;
    end
  end
endmodule

// File: tb/tb_mem_req_buffer.sv
// Scoreboard bench for mem_req_buffer: directed scenarios plus random traffic
// checked each cycle against a queue-based reference model.
module tb_mem_req_buffer;
  localparam int ADDR_W = 32, DATA_W = 32, DEPTH = 4, MAX_OUT = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid_i = 0, req_ready_o, req_we_i = 0, mem_valid_o, mem_ready_i = 0, mem_we_o;
  logic [ADDR_W-1:0] req_addr_i = '0, mem_addr_o;
  logic [3:0] req_be_i = '0, mem_be_o;
  logic [DATA_W-1:0] req_wdata_i = '0, mem_wdata_o, mem_rdata_i = '0, resp_rdata_o;
  logic mem_rvalid_i = 0, resp_rvalid_o, idle_o, err_o;
  logic [2:0] count_o;
  logic [1:0] outstanding_o;

  mem_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .resp_rvalid_o(resp_rvalid_o),
    .resp_rdata_o(resp_rdata_o), .count_o(count_o), .outstanding_o(outstanding_o),
    .idle_o(idle_o), .err_o(err_o));

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic we; logic [3:0] be; logic [DATA_W-1:0] wdata; } req_t;

  int checks = 0, errors = 0;
  req_t iq[$];               // accepted, not yet issued, in order
  logic [DATA_W-1:0] rq[$];  // responses due on resp_* next cycle
  int mod_out = 0;
  bit mod_err = 0, rst_seen = 0;
  logic [DATA_W-1:0] mod_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sampled mid-cycle, predicts the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready_o, 0);
      chk("rst_mvalid", mem_valid_o, 0);
      chk("rst_idle", idle_o, 1);
      if (rst_seen) begin
        chk("rst_count", count_o, 0);
        chk("rst_out", outstanding_o, 0);
        chk("rst_rvalid", resp_rvalid_o, 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_err", err_o, 0);
      end
      iq.delete(); rq.delete();
      mod_out = 0; mod_err = 0; mod_rdata = '0; rst_seen = 1;
    end else begin
      bit exp_v, push, pop, rsp, iss_rd;
      rst_seen = 0;
      exp_v = (iq.size() != 0) && !(!iq[0].we && mod_out == MAX_OUT);
      chk("count", count_o, iq.size());
      chk("outstanding", outstanding_o, mod_out);
      chk("ready", req_ready_o, iq.size() != DEPTH);
      chk("mem_valid", mem_valid_o, exp_v);
      chk("idle", idle_o, iq.size() == 0 && mod_out == 0);
      chk("err", err_o, mod_err);
      if (rq.size() != 0) begin
        mod_rdata = rq.pop_front();
        chk("resp_rvalid", resp_rvalid_o, 1);
      end else chk("resp_rvalid", resp_rvalid_o, 0);
      chk("resp_rdata", resp_rdata_o, mod_rdata);
      if (exp_v) begin
        chk("mem_addr", mem_addr_o, iq[0].addr);
        chk("mem_we", mem_we_o, iq[0].we);
        if (iq[0].we) begin
          chk("mem_be", mem_be_o, iq[0].be);
          chk("mem_wdata", mem_wdata_o, iq[0].wdata);
        end
      end
      push   = req_valid_i && (iq.size() != DEPTH);
      pop    = exp_v && mem_ready_i;
      iss_rd = pop && !iq[0].we;
      rsp    = mem_rvalid_i && mod_out > 0;
      if (mem_rvalid_i && mod_out == 0) mod_err = 1;
      if (rsp) rq.push_back(mem_rdata_i);
      if (pop) void'(iq.pop_front());
      if (push) iq.push_back('{req_addr_i, req_we_i, req_be_i, req_wdata_i});
      mod_out = mod_out + int'(iss_rd) - int'(rsp);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_req(input bit v, input bit we, input logic [31:0] a);
    req_valid_i = v; req_we_i = we; req_addr_i = a;
    req_be_i = 4'($urandom); req_wdata_i = $urandom;
  endtask

  task automatic do_reset();
    req_valid_i = 0; mem_ready_i = 0; mem_rvalid_i = 0;
    rst_n = 0; step(3); rst_n = 1; step(1);
  endtask

  initial begin
    step(3); rst_n = 1; step(1);

    // Fill with memory stalled
    for (int i = 0; i < 4; i++) begin drive_req(1, 1, 32'h100 + i); step(); end
    chk("fill_count", count_o, 4);
    chk("fill_ready", req_ready_o, 0);
    drive_req(1, 1, 32'h1FF); step();
    chk("fill_count5", count_o, 4);
    chk("fill_head", mem_addr_o, 32'h100);
    req_valid_i = 0; mem_ready_i = 1; step(5);

    // Read limit with MAX_OUT=2
    for (int i = 0; i < 3; i++) begin drive_req(1, 0, 32'h200 + i); step(); end
    req_valid_i = 0; step();
    chk("lim_out", outstanding_o, 2);
    chk("lim_count", count_o, 1);
    chk("lim_mvalid", mem_valid_o, 0);
    step(2);
    chk("lim_hold", mem_valid_o, 0);
    mem_rvalid_i = 1; mem_rdata_i = 32'h12345678; step(); mem_rvalid_i = 0;
    chk("lim_release", mem_valid_o, 1);
    chk("lim_addr3", mem_addr_o, 32'h202);
    step();
    chk("lim_out2", outstanding_o, 2);
    chk("lim_empty", count_o, 0);

    // Registered response
    mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF; step(); mem_rvalid_i = 0;
    chk("rsp_valid", resp_rvalid_o, 1);
    chk("rsp_data", resp_rdata_o, 32'hDEADBEEF);
    chk("rsp_out", outstanding_o, 1);
    step();
    chk("rsp_hold", resp_rdata_o, 32'hDEADBEEF);

    // Issue and response together at outstanding=1
    drive_req(1, 0, 32'h300); step(); req_valid_i = 0;
    mem_rvalid_i = 1; mem_rdata_i = $urandom; step(); mem_rvalid_i = 0;
    chk("sim_out", outstanding_o, 1);

    // Push and pop together at count=2
    mem_ready_i = 0;
    drive_req(1, 1, 32'h400); step(); drive_req(1, 1, 32'h404); step();
    chk("pp_pre", count_o, 2);
    mem_ready_i = 1; drive_req(1, 1, 32'h408); step(); req_valid_i = 0;
    chk("pp_count", count_o, 2);
    step(4);
    mem_rvalid_i = 1; mem_rdata_i = $urandom; step(); mem_rvalid_i = 0; step();
    chk("drain_idle", idle_o, 1);

    // Spurious response
    mem_rvalid_i = 1; mem_rdata_i = $urandom; step(); mem_rvalid_i = 0;
    chk("spur_err", err_o, 1);
    chk("spur_rvalid", resp_rvalid_o, 0);
    step(3);
    chk("spur_sticky", err_o, 1);

    // Reset mid-operation, then a late response
    for (int i = 0; i < 5; i++) begin drive_req(1, 0, 32'h500 + i); step(); end
    req_valid_i = 0;
    chk("mid_count", count_o, 3);
    chk("mid_out", outstanding_o, 2);
    rst_n = 0; step(); rst_n = 1; mem_ready_i = 0;
    chk("mid_rcount", count_o, 0);
    chk("mid_rout", outstanding_o, 0);
    chk("mid_ridle", idle_o, 1);
    step();
    mem_rvalid_i = 1; mem_rdata_i = $urandom; step(); mem_rvalid_i = 0;
    chk("late_err", err_o, 1);
    chk("late_rvalid", resp_rvalid_o, 0);

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive_req(($urandom % 3) != 0, $urandom % 2, $urandom);
      mem_ready_i  = ($urandom % 4) != 0;
      mem_rvalid_i = (mod_out > 0) && (($urandom % 3) == 0);
      mem_rdata_i  = $urandom;
      step();
    end
    req_valid_i = 0; mem_ready_i = 1;
    for (int c = 0; c < 50 && !(iq.size() == 0 && mod_out == 0); c++) begin
      mem_rvalid_i = (mod_out > 0); mem_rdata_i = $urandom; step();
    end
    mem_rvalid_i = 0; step(2);
    chk("final_idle", idle_o, 1);
    chk("final_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
